// File: rtl/accelerator_pkg.sv
// accelerator_pkg: shared types and defaults for the accelerator data path.
//   arb_master_t        - owner ID of a data-port transaction (core LSU / vector LSU)
//   ARB_MAX_OUTSTANDING - default depth of the arbiter's in-order ID FIFO
package accelerator_pkg;

  typedef enum logic {
    ARB_M0_CORE = 1'b0,
    ARB_M1_VLSU = 1'b1
  } arb_master_t;

  localparam int unsigned ARB_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: synchronous in-order FIFO of transaction owner IDs.
// Same-cycle push and pop are supported; a push while full or a pop while
// empty is ignored.
// Ports:
//   clk, n_reset      - clock, asynchronous active-low reset (FIFO empties)
//   push_i, data_i    - enqueue the owner ID data_i
//   pop_i             - dequeue the head entry
//   data_o            - head entry (valid when empty_o=0)
//   full_o, empty_o   - occupancy flags
module arb_id_fifo
  import accelerator_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        push_i,
  input  arb_master_t data_i,
  input  logic        pop_i,
  output arb_master_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  arb_master_t      mem_q [DEPTH];
  arb_master_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    // Simultaneous push and pop leaves the count unchanged.
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= ARB_M0_CORE;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter: shares one OBI-style data port between the scalar core LSU
// (master 0) and the vector LSU (master 1).
//
// Handshake: a master raises mX_req_i with stable fields and holds them until
// mX_gnt_o; downstream, a transfer happens in the cycle data_req_o & data_gnt_i.
// Each granted transfer gets exactly one data_rvalid_i later, in order; the
// owner of each is recorded in an ID FIFO and the head steers rvalid back.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin priority; otherwise
// fixed priority with master 1 winning contention.
//
// Ports:
//   clk, n_reset                       - clock, async active-low reset
//   mX_req/we/be/addr/wdata_i          - master request channels
//   mX_gnt_o, mX_rvalid_o, mX_rdata_o  - master grant and response
//   data_req/we/be/addr/wdata_o        - downstream request (muxed by selection)
//   data_gnt_i, data_rvalid_i, data_rdata_i - downstream grant and response
//   err_o                              - sticky: rvalid with nothing outstanding
module obi_data_arbiter
  import accelerator_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        err_o
);

  arb_master_t sel;
  arb_master_t pri_winner;
  arb_master_t prev_sel_q, prev_sel_d;
  logic        lock_q, lock_d;
  logic        err_q, err_d;
  logic        granted;
  logic        fifo_full;
  logic        fifo_empty;
  arb_master_t fifo_head;

`ifdef ARB_ROUND_ROBIN_EN
  arb_master_t rr_q, rr_d;

  assign pri_winner = rr_q;

  // The pointer hands priority to the master that did not just win.
  always_comb begin
    rr_d = rr_q;
    if (granted) begin
      rr_d = (sel == ARB_M0_CORE) ? ARB_M1_VLSU : ARB_M0_CORE;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rr_q <= ARB_M0_CORE;
    else          rr_q <= rr_d;
  end
`else
  assign pri_winner = ARB_M1_VLSU;
`endif

  // While a downstream request waits for its grant the previous choice is
  // replayed, so the presented address never changes under the slave.
  always_comb begin
    sel = prev_sel_q;
    if (!lock_q) begin
      if (m0_req_i && m1_req_i) sel = pri_winner;
      else if (m1_req_i)        sel = ARB_M1_VLSU;
      else                      sel = ARB_M0_CORE;
    end
  end

  assign data_req_o   = (m0_req_i | m1_req_i) & ~fifo_full;
  assign granted      = data_req_o & data_gnt_i;
  assign m0_gnt_o     = granted & (sel == ARB_M0_CORE);
  assign m1_gnt_o     = granted & (sel == ARB_M1_VLSU);

  assign data_we_o    = (sel == ARB_M1_VLSU) ? m1_we_i    : m0_we_i;
  assign data_be_o    = (sel == ARB_M1_VLSU) ? m1_be_i    : m0_be_i;
  assign data_addr_o  = (sel == ARB_M1_VLSU) ? m1_addr_i  : m0_addr_i;
  assign data_wdata_o = (sel == ARB_M1_VLSU) ? m1_wdata_i : m0_wdata_i;

  // A response with an empty FIFO has no owner: drop it and flag the error.
  assign m0_rvalid_o  = data_rvalid_i & ~fifo_empty & (fifo_head == ARB_M0_CORE);
  assign m1_rvalid_o  = data_rvalid_i & ~fifo_empty & (fifo_head == ARB_M1_VLSU);
  assign m0_rdata_o   = data_rdata_i;
  assign m1_rdata_o   = data_rdata_i;
  assign err_o        = err_q;

  always_comb begin
    lock_d     = data_req_o & ~data_gnt_i;
    prev_sel_d = sel;
    err_d      = err_q | (data_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lock_q     <= 1'b0;
      prev_sel_q <= ARB_M0_CORE;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      prev_sel_q <= prev_sel_d;
      err_q      <= err_d;
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push_i  (granted),
    .data_i  (sel),
    .pop_i   (data_rvalid_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_obi_data_arbiter.sv
// tb_obi_data_arbiter: directed tests for obi_data_arbiter. Expected owners are
// queued when a grant is expected and popped when the bench drives a response.
// Works for both priority builds (ARB_ROUND_ROBIN_EN defined or not).
module tb_obi_data_arbiter;

  logic        clk;
  logic        n_reset;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, err_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

  logic [0:0]  exp_q[$];
  int          n_checks;
  int          n_errors;

  obi_data_arbiter dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .m0_req_i      (m0_req_i),
    .m0_we_i       (m0_we_i),
    .m0_be_i       (m0_be_i),
    .m0_addr_i     (m0_addr_i),
    .m0_wdata_i    (m0_wdata_i),
    .m0_gnt_o      (m0_gnt_o),
    .m0_rvalid_o   (m0_rvalid_o),
    .m0_rdata_o    (m0_rdata_o),
    .m1_req_i      (m1_req_i),
    .m1_we_i       (m1_we_i),
    .m1_be_i       (m1_be_i),
    .m1_addr_i     (m1_addr_i),
    .m1_wdata_i    (m1_wdata_i),
    .m1_gnt_o      (m1_gnt_o),
    .m1_rvalid_o   (m1_rvalid_o),
    .m1_rdata_o    (m1_rdata_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .err_o         (err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    m0_req_i = 0; m1_req_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
  endtask

  task automatic do_reset();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    idle();
    n_reset = 0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: inputs already set by caller (plus rvalid/rdata here); outputs
  // sampled mid-cycle. exp_sel: master whose fields should be on the bus (-1 =
  // don't care); gnt_exp: whether that master should be granted now.
  task automatic cyc(input logic exp_req, input int exp_sel, input logic gnt_exp,
                     input logic rv, input logic [31:0] rd);
    logic [0:0] own;
    data_rvalid_i = rv;
    data_rdata_i  = rd;
    #2;
    check_eq("data_req", 32'(data_req_o), 32'(exp_req));
    check_eq("m0_gnt", 32'(m0_gnt_o), 32'(gnt_exp && exp_sel == 0));
    check_eq("m1_gnt", 32'(m1_gnt_o), 32'(gnt_exp && exp_sel == 1));
    if (exp_sel >= 0) begin
      check_eq("data_addr", data_addr_o, (exp_sel == 1) ? m1_addr_i : m0_addr_i);
      check_eq("data_we", 32'(data_we_o), 32'((exp_sel == 1) ? m1_we_i : m0_we_i));
      check_eq("data_be", 32'(data_be_o), 32'((exp_sel == 1) ? m1_be_i : m0_be_i));
      check_eq("data_wdata", data_wdata_o, (exp_sel == 1) ? m1_wdata_i : m0_wdata_i);
    end
    if (rv) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        own = exp_q.pop_front();
        check_eq("m0_rvalid", 32'(m0_rvalid_o), 32'(own == 1'b0));
        check_eq("m1_rvalid", 32'(m1_rvalid_o), 32'(own == 1'b1));
        check_eq(own ? "m1_rdata" : "m0_rdata", own ? m1_rdata_o : m0_rdata_o, rd);
      end
    end
    if (gnt_exp && exp_sel >= 0) exp_q.push_back(exp_sel[0]);
    @(posedge clk);
    #1;
    data_rvalid_i = 0;
  endtask

  // ---------------- tests ----------------
  int own_seq[4];
  logic [31:0] r;

  initial begin
    n_checks = 0; n_errors = 0;
    n_reset = 0;
    idle();
    m0_we_i = 1; m0_be_i = 4'hf; m0_addr_i = 32'h200; m0_wdata_i = 32'hA5A5_0000;
    m1_we_i = 0; m1_be_i = 4'h3; m1_addr_i = 32'h300; m1_wdata_i = 32'h1234_5678;
    do_reset();

    // Reset state, idle inputs
    #2;
    check_eq("rst_m0_gnt", 32'(m0_gnt_o), 0);
    check_eq("rst_m1_gnt", 32'(m1_gnt_o), 0);
    check_eq("rst_m0_rvalid", 32'(m0_rvalid_o), 0);
    check_eq("rst_m1_rvalid", 32'(m1_rvalid_o), 0);
    check_eq("rst_data_req", 32'(data_req_o), 0);
    check_eq("rst_err", 32'(err_o), 0);
    @(posedge clk); #1;

    // Single read by m0
    m0_we_i = 0; m0_addr_i = 32'h100;
    m0_req_i = 1; data_gnt_i = 1;
    cyc(1, 0, 1, 0, '0);
    m0_req_i = 0; data_gnt_i = 0;
    cyc(0, -1, 0, 1, 32'hDEAD_BEEF);
    cyc(0, -1, 0, 0, '0);

    // Contention
    do_reset();
    m0_we_i = 1; m0_addr_i = 32'h200;
`ifdef ARB_ROUND_ROBIN_EN
    own_seq = '{0, 1, 0, 0};
`else
    own_seq = '{1, 1, 1, 0};
`endif
    m0_req_i = 1; m1_req_i = 1; data_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m1_req_i = 0;
      m0_addr_i = 32'h200 + 32'(i * 4);
      m1_addr_i = 32'h300 + 32'(i * 4);
      r = $urandom;
      cyc(1, own_seq[i], 1, i > 0, r);
    end
    m0_req_i = 0; data_gnt_i = 0;
    cyc(0, -1, 0, 1, 32'h0BAD_F00D);

    // Lock: m0 selected, grant withheld while m1 joins
    do_reset();
    m0_addr_i = 32'h400; m1_addr_i = 32'h500;
    m0_req_i = 1; data_gnt_i = 0;
    cyc(1, 0, 0, 0, '0);
    m1_req_i = 1;
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    data_gnt_i = 1;
    cyc(1, 0, 1, 0, '0);
    m0_req_i = 0;
    cyc(1, 1, 1, 0, '0);
    m1_req_i = 0; data_gnt_i = 0;
    cyc(0, -1, 0, 1, 32'h1111_0000);
    cyc(0, -1, 0, 1, 32'h2222_0000);

    // Full FIFO and push/pop at count 1
    do_reset();
    m0_req_i = 1; data_gnt_i = 1;
    cyc(1, 0, 1, 0, '0);
    cyc(1, 0, 1, 0, '0);
    cyc(0, -1, 0, 1, 32'h3333_0001);   // full: blocked, response frees a slot
    cyc(1, 0, 1, 0, '0);               // re-asserts and refills
    cyc(0, -1, 0, 1, 32'h3333_0002);
    cyc(1, 0, 1, 1, 32'h3333_0003);    // push + pop at count 1
    data_gnt_i = 0;
    cyc(1, 0, 0, 0, '0);               // still count 1: not full
    data_gnt_i = 1;
    cyc(1, 0, 1, 0, '0);
    m0_req_i = 0; data_gnt_i = 0;
    cyc(0, -1, 0, 1, 32'h3333_0004);
    cyc(0, -1, 0, 1, 32'h3333_0005);

    // Mixed owners return in grant order
    do_reset();
    data_gnt_i = 1;
    m1_req_i = 1;
    cyc(1, 1, 1, 0, '0);
    m1_req_i = 0; m0_req_i = 1;
    cyc(1, 0, 1, 0, '0);
    m0_req_i = 0; m1_req_i = 1;
    cyc(0, -1, 0, 1, 32'h4444_0001);
    cyc(1, 1, 1, 0, '0);
    m1_req_i = 0; data_gnt_i = 0;
    cyc(0, -1, 0, 1, 32'h4444_0002);
    cyc(0, -1, 0, 1, 32'h4444_0003);

    // Spurious response with nothing outstanding
    do_reset();
    data_rvalid_i = 1; data_rdata_i = 32'hCAFE_CAFE;
    #2;
    check_eq("spur_m0_rvalid", 32'(m0_rvalid_o), 0);
    check_eq("spur_m1_rvalid", 32'(m1_rvalid_o), 0);
    check_eq("spur_err_pre", 32'(err_o), 0);
    @(posedge clk); #1;
    data_rvalid_i = 0;
    #2;
    check_eq("spur_err_set", 32'(err_o), 1);
    repeat (3) @(posedge clk);
    #2;
    check_eq("spur_err_sticky", 32'(err_o), 1);
    check_eq("sb_final", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
